// File: rtl/unidad_escritura_registros.sv
// Write-back front end for the register bank: a small FIFO that issues one registered write per cycle.
// Optional macro WB_BYPASS_EN adds read-port bypass of pending writes (hit1/hit2, byp1/byp2).
module unidad_escritura_registros #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 5,
   parameter int unsigned DW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] in_dir,
   input  logic [DW-1:0] in_dato,
   input  logic          bloqueo,
   input  logic          vaciar,
   output logic [AW-1:0] Dir,
   output logic [DW-1:0] Di,
   output logic          RegWrite,
   output logic          pendiente,
   input  logic [AW-1:0] RA1,
   input  logic [AW-1:0] RA2,
   output logic          hit1,
   output logic          hit2,
   output logic [DW-1:0] byp1,
   output logic [DW-1:0] byp2
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   logic [AW-1:0] mem_dir  [DEPTH];
   logic [DW-1:0] mem_dato [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          accept;
   logic          push;
   logic          pop;

   assign in_ready  = (count != CW'(DEPTH)) && !vaciar;
   assign accept    = in_valid && in_ready;
   // Writes to $zero complete the handshake but are dropped here.
   assign push      = accept && (in_dir != AW'(0));
   assign pop       = (count != CW'(0)) && !bloqueo && !vaciar;
   assign pendiente = (count != CW'(0)) || RegWrite;

   // Entry storage; contents outside [rd_ptr, rd_ptr+count) are never observed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_dir[wr_ptr]  <= in_dir;
         mem_dato[wr_ptr] <= in_dato;
      end
   end

   // Pointers, occupancy and the registered bank-write stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         Dir      <= '0;
         Di       <= '0;
         RegWrite <= 1'b0;
      end else if (vaciar) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         RegWrite <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            Dir      <= mem_dir[rd_ptr];
            Di       <= mem_dato[rd_ptr];
            rd_ptr   <= rd_ptr + PW'(1);
            RegWrite <= 1'b1;
         end else begin
            RegWrite <= 1'b0;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

`ifdef WB_BYPASS_EN
   // Oldest first (output stage, then FIFO head to tail) so the youngest match wins.
   always_comb begin
      logic [PW-1:0] idx;
      hit1 = 1'b0;
      hit2 = 1'b0;
      byp1 = '0;
      byp2 = '0;
      idx  = '0;
      if (RegWrite && (Dir == RA1)) begin
         hit1 = 1'b1;
         byp1 = Di;
      end
      if (RegWrite && (Dir == RA2)) begin
         hit2 = 1'b1;
         byp2 = Di;
      end
      for (int k = 0; k < int'(DEPTH); k++) begin
         idx = rd_ptr + PW'(k);
         if (CW'(k) < count) begin
            if (mem_dir[idx] == RA1) begin
               hit1 = 1'b1;
               byp1 = mem_dato[idx];
            end
            if (mem_dir[idx] == RA2) begin
               hit2 = 1'b1;
               byp2 = mem_dato[idx];
            end
         end
      end
      if (RA1 == AW'(0)) begin
         hit1 = 1'b0;
         byp1 = '0;
      end
      if (RA2 == AW'(0)) begin
         hit2 = 1'b0;
         byp2 = '0;
      end
   end
`else
   logic unused_ra;
   assign unused_ra = ^{RA1, RA2};
   assign hit1 = 1'b0;
   assign hit2 = 1'b0;
   assign byp1 = '0;
   assign byp2 = '0;
`endif

endmodule

// File: tb/tb_unidad_escritura_registros.sv
// Directed, table-driven bench for unidad_escritura_registros, plus an async-reset-mid-drain sequence.
module tb_unidad_escritura_registros;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_dir;
   logic [31:0] in_dato;
   logic        bloqueo;
   logic        vaciar;
   logic [4:0]  Dir;
   logic [31:0] Di;
   logic        RegWrite;
   logic        pendiente;
   logic [4:0]  RA1;
   logic [4:0]  RA2;
   logic        hit1;
   logic        hit2;
   logic [31:0] byp1;
   logic [31:0] byp2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   unidad_escritura_registros #(.DEPTH(4), .AW(5), .DW(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_dir(in_dir), .in_dato(in_dato), .bloqueo(bloqueo), .vaciar(vaciar),
      .Dir(Dir), .Di(Di), .RegWrite(RegWrite), .pendiente(pendiente),
      .RA1(RA1), .RA2(RA2), .hit1(hit1), .hit2(hit2), .byp1(byp1), .byp2(byp2)
   );

   typedef struct {
      logic        v;
      logic [4:0]  dir;
      logic [31:0] dato;
      logic        bl;
      logic        vac;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic        e_rdy;
      logic        e_rw;
      logic [4:0]  e_dir;
      logic [31:0] e_di;
      logic        e_pend;
      logic        e_hit1;
      logic [31:0] e_byp1;
      logic        e_hit2;
   } row_t;

   row_t rows[$];

   function automatic row_t mk(logic v, logic [4:0] dir, logic [31:0] dato, logic bl, logic vac,
                               logic [4:0] ra1, logic [4:0] ra2, logic rdy, logic rw,
                               logic [4:0] edir, logic [31:0] edi, logic pend,
                               logic h1, logic [31:0] b1, logic h2);
      row_t r;
      r.v = v; r.dir = dir; r.dato = dato; r.bl = bl; r.vac = vac; r.ra1 = ra1; r.ra2 = ra2;
      r.e_rdy = rdy; r.e_rw = rw; r.e_dir = edir; r.e_di = edi; r.e_pend = pend;
      r.e_hit1 = h1; r.e_byp1 = b1; r.e_hit2 = h2;
      return r;
   endfunction

   task automatic add(logic v, logic [4:0] dir, logic [31:0] dato, logic bl, logic vac,
                      logic [4:0] ra1, logic [4:0] ra2, logic rdy, logic rw,
                      logic [4:0] edir, logic [31:0] edi, logic pend,
                      logic h1, logic [31:0] b1, logic h2);
      rows.push_back(mk(v, dir, dato, bl, vac, ra1, ra2, rdy, rw, edir, edi, pend, h1, b1, h2));
   endtask

   task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   // Drive a row just after a rising edge, check at the falling edge, then take the next edge.
   task automatic run_row(row_t r, int idx);
      in_valid = r.v; in_dir = r.dir; in_dato = r.dato;
      bloqueo = r.bl; vaciar = r.vac; RA1 = r.ra1; RA2 = r.ra2;
      @(negedge clk);
      chk("in_ready", idx, 32'(in_ready), 32'(r.e_rdy));
      chk("RegWrite", idx, 32'(RegWrite), 32'(r.e_rw));
      chk("Dir", idx, 32'(Dir), 32'(r.e_dir));
      chk("Di", idx, Di, r.e_di);
      chk("pendiente", idx, 32'(pendiente), 32'(r.e_pend));
      chk("hit1", idx, 32'(hit1), 32'(BYP & r.e_hit1));
      chk("byp1", idx, byp1, (BYP & r.e_hit1) ? r.e_byp1 : 32'h0);
      chk("hit2", idx, 32'(hit2), 32'(BYP & r.e_hit2));
      chk("byp2", idx, byp2, 32'h0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Single write: accept, then bank write two edges later.
      add(0, 0, 0,          0, 0, 0, 0, 1, 0, 0, 32'h0,   0, 0, 0, 0);
      add(1, 5, 32'h000000AA, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 0, 0);
      add(0, 0, 0,          0, 0, 0, 0, 1, 0, 0, 32'h0,   1, 0, 0, 0);
      add(0, 0, 0,          0, 0, 0, 0, 1, 1, 5, 32'hAA,  1, 0, 0, 0);
      add(0, 0, 0,          0, 0, 0, 0, 1, 0, 5, 32'hAA,  0, 0, 0, 0);
      // Five pushes under stall; the fifth is refused until draining starts.
      add(1, 1, 32'h101, 1, 0, 0, 0, 1, 0, 5, 32'hAA,  0, 0, 0, 0);
      add(1, 2, 32'h102, 1, 0, 0, 0, 1, 0, 5, 32'hAA,  1, 0, 0, 0);
      add(1, 3, 32'h103, 1, 0, 0, 0, 1, 0, 5, 32'hAA,  1, 0, 0, 0);
      add(1, 4, 32'h104, 1, 0, 0, 0, 1, 0, 5, 32'hAA,  1, 0, 0, 0);
      add(1, 5, 32'h105, 1, 0, 0, 0, 0, 0, 5, 32'hAA,  1, 0, 0, 0);
      add(1, 5, 32'h105, 0, 0, 0, 0, 0, 0, 5, 32'hAA,  1, 0, 0, 0);
      add(1, 5, 32'h105, 0, 0, 0, 0, 1, 1, 1, 32'h101, 1, 0, 0, 0);
      add(0, 0, 0,       0, 0, 0, 0, 1, 1, 2, 32'h102, 1, 0, 0, 0);
      add(0, 0, 0,       0, 0, 0, 0, 1, 1, 3, 32'h103, 1, 0, 0, 0);
      add(0, 0, 0,       0, 0, 0, 0, 1, 1, 4, 32'h104, 1, 0, 0, 0);
      add(0, 0, 0,       0, 0, 0, 0, 1, 1, 5, 32'h105, 1, 0, 0, 0);
      add(0, 0, 0,       0, 0, 0, 0, 1, 0, 5, 32'h105, 0, 0, 0, 0);
      // Write to register zero: handshake only.
      add(1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, 5, 32'h105, 0, 0, 0, 0);
      add(0, 0, 0,            0, 0, 0, 0, 1, 0, 5, 32'h105, 0, 0, 0, 0);
      add(0, 0, 0,            0, 0, 0, 0, 1, 0, 5, 32'h105, 0, 0, 0, 0);
      // Fill three, flush with a concurrent push.
      add(1, 8,  32'h208, 1, 0, 0, 0, 1, 0, 5, 32'h105, 0, 0, 0, 0);
      add(1, 9,  32'h209, 1, 0, 0, 0, 1, 0, 5, 32'h105, 1, 0, 0, 0);
      add(1, 10, 32'h20A, 1, 0, 0, 0, 1, 0, 5, 32'h105, 1, 0, 0, 0);
      add(1, 11, 32'h20B, 1, 1, 0, 0, 0, 0, 5, 32'h105, 1, 0, 0, 0);
      add(0, 0, 0,        0, 0, 0, 0, 1, 0, 5, 32'h105, 0, 0, 0, 0);
      add(0, 0, 0,        0, 0, 0, 0, 1, 0, 5, 32'h105, 0, 0, 0, 0);
      // Bypass: two writes to r7, youngest wins across FIFO and output stage.
      add(1, 7, 32'h11, 1, 0, 7, 3, 1, 0, 5, 32'h105, 0, 0, 32'h0,  0);
      add(1, 7, 32'h22, 1, 0, 7, 3, 1, 0, 5, 32'h105, 1, 1, 32'h11, 0);
      add(0, 0, 0,      1, 0, 7, 3, 1, 0, 5, 32'h105, 1, 1, 32'h22, 0);
      add(0, 0, 0,      0, 0, 7, 3, 1, 0, 5, 32'h105, 1, 1, 32'h22, 0);
      add(0, 0, 0,      1, 0, 7, 3, 1, 1, 7, 32'h11,  1, 1, 32'h22, 0);
      add(0, 0, 0,      0, 0, 7, 3, 1, 0, 7, 32'h11,  1, 1, 32'h22, 0);
      add(0, 0, 0,      0, 0, 7, 3, 1, 1, 7, 32'h22,  1, 1, 32'h22, 0);
      add(0, 0, 0,      0, 0, 0, 0, 1, 0, 7, 32'h22,  0, 0, 32'h0,  0);

      rst_n = 1'b0; in_valid = 0; in_dir = 0; in_dato = 0;
      bloqueo = 0; vaciar = 0; RA1 = 0; RA2 = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < rows.size(); i++) begin
         run_row(rows[i], i);
      end

      // Async reset while two entries are pending and a write is on the bank.
      run_row(mk(1, 12, 32'h30C, 1, 0, 0, 0, 1, 0, 7, 32'h22, 0, 0, 0, 0), 100);
      run_row(mk(1, 13, 32'h30D, 1, 0, 0, 0, 1, 0, 7, 32'h22, 1, 0, 0, 0), 101);
      run_row(mk(1, 14, 32'h30E, 1, 0, 0, 0, 1, 0, 7, 32'h22, 1, 0, 0, 0), 102);
      run_row(mk(0, 0,  0,       0, 0, 0, 0, 1, 0, 7, 32'h22, 1, 0, 0, 0), 103);
      chk("pre_reset_RegWrite", 104, 32'(RegWrite), 32'h1);
      chk("pre_reset_Dir", 104, 32'(Dir), 32'd12);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_RegWrite", 105, 32'(RegWrite), 32'h0);
      chk("async_Dir", 105, 32'(Dir), 32'h0);
      chk("async_Di", 105, Di, 32'h0);
      chk("async_pendiente", 105, 32'(pendiente), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         run_row(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 0, 0), 110 + i);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
